// File: rtl/falu_cnv_fp2int_pkg.sv
// Shared constants and types for the FP-to-integer converter: rounding-mode
// encodings, IEEE field widths/biases, saturation limits, FSM and record types.
package falu_cnv_fp2int_pkg;

  localparam logic [2:0] FCSR_FRM_RNE = 3'b000;
  localparam logic [2:0] FCSR_FRM_RTZ = 3'b001;
  localparam logic [2:0] FCSR_FRM_RDN = 3'b010;
  localparam logic [2:0] FCSR_FRM_RUP = 3'b011;
  localparam logic [2:0] FCSR_FRM_RMM = 3'b100;

  localparam int SP_EXP_W  = 8;
  localparam int SP_FRAC_W = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_FRAC_W = 52;
  localparam logic signed [12:0] SP_BIAS = 13'sd127;
  localparam logic signed [12:0] DP_BIAS = 13'sd1023;

  localparam logic [63:0] WORD_SMAX = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] WORD_SMIN = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] WORD_UMAX = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] LONG_SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] LONG_SMIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] LONG_UMAX = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // sig is left-aligned to 53 bits for both formats, so value = sig * 2^(exp-52)
  typedef struct packed {
    logic               sign;
    logic signed [12:0] exp;
    logic [52:0]        sig;
    logic               is_zero;
    logic               is_inf;
    logic               is_nan;
  } unpack_t;

  typedef struct packed {
    logic [63:0] res;
    logic        nv;
    logic        nx;
  } sat_t;

endpackage

// File: rtl/fp2int_unpack.sv
// Splits an SP or DP operand into sign, unbiased exponent and significand and
// classifies it; an improperly NaN-boxed SP operand reads as a NaN.
module fp2int_unpack
  import falu_cnv_fp2int_pkg::*;
(
  input  logic [63:0] operand,
  input  logic        is_double,
  output unpack_t     fields
);

  logic [10:0] ef;
  logic [51:0] fr;
  logic        boxed;
  logic        hidden;
  logic        exp_max;

  assign boxed   = &operand[63:32];
  assign ef      = is_double ? operand[DP_FRAC_W +: DP_EXP_W]
                             : {3'b000, operand[SP_FRAC_W +: SP_EXP_W]};
  assign fr      = is_double ? operand[DP_FRAC_W-1:0]
                             : {operand[SP_FRAC_W-1:0], 29'd0};
  assign hidden  = (ef != 11'd0);
  assign exp_max = is_double ? (ef == 11'h7FF) : (ef == 11'h0FF);

  // Denormals use exponent 1 with a cleared hidden bit
  always_comb begin
    fields         = '0;
    fields.sign    = is_double ? operand[63] : (operand[31] & boxed);
    fields.exp     = $signed({2'b00, (hidden ? ef : 11'd1)}) - (is_double ? DP_BIAS : SP_BIAS);
    fields.sig     = {hidden, fr};
    fields.is_zero = (ef == 11'd0) && (fr == 52'd0);
    fields.is_inf  = exp_max && (fr == 52'd0) && (is_double || boxed);
    fields.is_nan  = (exp_max && (fr != 52'd0)) || (!is_double && !boxed);
  end

endmodule

// File: rtl/falu_cnv_fp2int.sv
// Multi-cycle FP (SP/DP) to integer converter: accept, align to a 64-bit
// magnitude with guard/sticky, round, saturate, then hold until consumed.
module falu_cnv_fp2int
  import falu_cnv_fp2int_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [63:0] INPUT,
  input  logic [2:0]  Rounding_Mode,
  input  logic        IsDouble,
  input  logic        IsWord,
  input  logic        Is_Unsigned,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] OUTPUT,
  output logic        INVALID,
  output logic        INEXACT
);

  state_t      state, state_nxt;
  logic [63:0] op_p0;
  logic [2:0]  frm_p0;
  logic        dbl_p0, word_p0, uns_p0;
  unpack_t     up;
  logic [116:0] wide;
  logic [6:0]  sh;
  logic [63:0] mag_al;
  logic        g_al, s_al, ovf_al;
  logic [63:0] mag_p1;
  logic        g_p1, s_p1, sign_p1, nan_p1, inf_p1, ovf_p1;
  logic [64:0] rnd;
  sat_t        sat;

  function automatic logic round_inc(input logic [2:0] frm, input logic sign,
                                     input logic l, input logic g, input logic s);
    case (frm)
      FCSR_FRM_RNE: round_inc = g & (l | s);
      FCSR_FRM_RDN: round_inc = sign & (g | s);
      FCSR_FRM_RUP: round_inc = ~sign & (g | s);
      FCSR_FRM_RMM: round_inc = g;
      default:      round_inc = 1'b0;
    endcase
  endfunction

  // A negative value rounding to zero is not out of range even when unsigned
  function automatic sat_t saturate(input logic sign, input logic word, input logic uns,
                                    input logic nan, input logic inf, input logic ovf,
                                    input logic [64:0] mag, input logic g, input logic s);
    sat_t        r;
    logic [63:0] vmax, vmin, neg_lim;
    logic        too_big;
    vmax    = word ? (uns ? WORD_UMAX : WORD_SMAX) : (uns ? LONG_UMAX : LONG_SMAX);
    vmin    = uns ? 64'd0 : (word ? WORD_SMIN : LONG_SMIN);
    neg_lim = ~vmin + 64'd1;
    too_big = sign ? (uns ? (mag != 65'd0) : (mag > {1'b0, neg_lim}))
                   : (mag > {1'b0, vmax});
    r.nv  = 1'b0;
    r.nx  = g | s;
    r.res = sign ? (~mag[63:0] + 64'd1) : mag[63:0];
    if (nan) begin
      r.res = vmax;
      r.nv  = 1'b1;
      r.nx  = 1'b0;
    end else if (inf || ovf || too_big) begin
      r.res = sign ? vmin : vmax;
      r.nv  = 1'b1;
      r.nx  = 1'b0;
    end
    if (word) r.res = {{32{r.res[31]}}, r.res[31:0]};
    saturate = r;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (IN_VALID) state_nxt = ST_ALIGN;
      ST_ALIGN: state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_DONE;
      ST_DONE:  if (OUT_READY) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (FLUSH) state_nxt = ST_IDLE;
  end

  always_comb begin
    IN_READY  = (state == ST_IDLE);
    OUT_VALID = (state == ST_DONE);
  end

  // Stage p0: operand and controls captured on accept
  always_ff @(posedge CLK) begin
    if (IN_VALID && IN_READY) begin
      op_p0   <= INPUT;
      frm_p0  <= Rounding_Mode;
      dbl_p0  <= IsDouble;
      word_p0 <= IsWord;
      uns_p0  <= Is_Unsigned;
    end
  end

  fp2int_unpack u_unpack (
    .operand   (op_p0),
    .is_double (dbl_p0),
    .fields    (up)
  );

  // Integer part lands in wide[116:53], guard at 52, sticky below
  always_comb begin
    wide   = '0;
    sh     = '0;
    mag_al = '0;
    g_al   = 1'b0;
    s_al   = 1'b0;
    ovf_al = (up.exp >= 13'sd64);
    if (up.is_zero || ovf_al) begin
      s_al = 1'b0;
    end else if (up.exp < -13'sd1) begin
      s_al = |up.sig;
    end else begin
      sh     = 7'(up.exp + 13'sd1);
      wide   = {64'd0, up.sig} << sh;
      mag_al = wide[116:53];
      g_al   = wide[52];
      s_al   = |wide[51:0];
    end
  end

  // Stage p1: aligned magnitude, guard and sticky
  always_ff @(posedge CLK) begin
    if (state == ST_ALIGN) begin
      mag_p1  <= mag_al;
      g_p1    <= g_al;
      s_p1    <= s_al;
      sign_p1 <= up.sign;
      nan_p1  <= up.is_nan;
      inf_p1  <= up.is_inf;
      ovf_p1  <= ovf_al;
    end
  end

  assign rnd = {1'b0, mag_p1} + 65'(round_inc(frm_p0, sign_p1, mag_p1[0], g_p1, s_p1));
  assign sat = saturate(sign_p1, word_p0, uns_p0, nan_p1, inf_p1, ovf_p1, rnd, g_p1, s_p1);

  // Stage p2: rounded, range-checked result held through DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUTPUT  <= 64'd0;
      INVALID <= 1'b0;
      INEXACT <= 1'b0;
    end else if (state == ST_ROUND) begin
      OUTPUT  <= sat.res;
      INVALID <= sat.nv;
      INEXACT <= sat.nx;
    end
  end

endmodule

// File: tb/tb_falu_cnv_fp2int.sv
// Directed bench for falu_cnv_fp2int: a vector table of conversions plus
// handshake, flush and reset sequences.
module tb_falu_cnv_fp2int;

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

  typedef struct {
    logic [63:0] val;
    logic [2:0]  rm;
    logic        dbl, word, uns;
    logic [63:0] want;
    logic        nv, nx;
  } vec_t;

  logic        CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0, IN_READY;
  logic [63:0] INPUT = '0;
  logic [2:0]  Rounding_Mode = '0;
  logic        IsDouble = 1'b0, IsWord = 1'b0, Is_Unsigned = 1'b0, FLUSH = 1'b0;
  logic        OUT_VALID, OUT_READY = 1'b0;
  logic [63:0] OUTPUT;
  logic        INVALID, INEXACT;

  int   total = 0, bad = 0;
  vec_t vecs[$];

  falu_cnv_fp2int dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INPUT(INPUT),
    .Rounding_Mode(Rounding_Mode), .IsDouble(IsDouble), .IsWord(IsWord),
    .Is_Unsigned(Is_Unsigned), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUTPUT(OUTPUT), .INVALID(INVALID), .INEXACT(INEXACT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic add(input logic [63:0] val, input logic [2:0] rm, input logic dbl,
                     input logic word, input logic uns, input logic [63:0] want,
                     input logic nv, input logic nx);
    vec_t v;
    v.val = val; v.rm = rm; v.dbl = dbl; v.word = word; v.uns = uns;
    v.want = want; v.nv = nv; v.nx = nx;
    vecs.push_back(v);
  endtask

  // Presents one operand and returns just after the accepting edge
  task automatic send(input logic [63:0] val, input logic [2:0] rm, input logic dbl,
                      input logic word, input logic uns);
    int guard = 0;
    @(negedge CLK);
    while (!IN_READY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 20) chk("in_ready_timeout", 64'(IN_READY), 64'd1);
    INPUT = val; Rounding_Mode = rm; IsDouble = dbl; IsWord = word; Is_Unsigned = uns;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      @(posedge CLK);
      #1 lat++;
    end
  endtask

  task automatic consume();
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
  endtask

  task automatic watch_quiet(input string nm, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK);
      #1 if (OUT_VALID) seen++;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [63:0] held;

    add(64'h4004000000000000, RNE, 1, 0, 0, 64'd2, 0, 1);
    add(64'h4004000000000000, RMM, 1, 0, 0, 64'd3, 0, 1);
    add(64'h4004000000000000, RTZ, 1, 0, 0, 64'd2, 0, 1);
    add(64'h4004000000000000, RUP, 1, 0, 0, 64'd3, 0, 1);
    add(64'h4004000000000000, 3'd7, 1, 0, 0, 64'd2, 0, 1);
    add(64'hC004000000000000, RNE, 1, 0, 0, 64'hFFFFFFFFFFFFFFFE, 0, 1);
    add(64'h400C000000000000, RNE, 1, 0, 0, 64'd4, 0, 1);
    add(64'h3FE0000000000000, RNE, 1, 0, 0, 64'd0, 0, 1);
    add(64'h3FE0000000000000, RMM, 1, 0, 0, 64'd1, 0, 1);
    add(64'hFFFFFFFFBFC00000, RDN, 0, 1, 0, 64'hFFFFFFFFFFFFFFFE, 0, 1);
    add(64'h00000000BFC00000, RDN, 0, 1, 0, 64'h000000007FFFFFFF, 1, 0);
    add(64'hFFFFFFFF3F800000, RNE, 0, 1, 0, 64'd1, 0, 0);
    add(64'h43E0000000000000, RNE, 1, 0, 0, 64'h7FFFFFFFFFFFFFFF, 1, 0);
    add(64'h43E0000000000000, RNE, 1, 0, 1, 64'h8000000000000000, 0, 0);
    add(64'hBFD0000000000000, RTZ, 1, 0, 1, 64'd0, 0, 1);
    add(64'hBFF0000000000000, RTZ, 1, 0, 1, 64'd0, 1, 0);
    add(64'hBFE0000000000000, RUP, 1, 0, 1, 64'd0, 0, 1);
    add(64'h41EFFFFFFFE00000, RTZ, 1, 1, 1, 64'hFFFFFFFFFFFFFFFF, 0, 0);
    add(64'h41E0000000000000, RNE, 1, 1, 0, 64'h000000007FFFFFFF, 1, 0);
    add(64'hC1E0000000000000, RNE, 1, 1, 0, 64'hFFFFFFFF80000000, 0, 0);
    add(64'h43F0000000000000, RNE, 1, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    add(64'h0000000000000000, RNE, 1, 0, 0, 64'd0, 0, 0);
    add(64'h8000000000000000, RNE, 1, 0, 0, 64'd0, 0, 0);
    add(64'h7FF0000000000000, RNE, 1, 1, 0, 64'h000000007FFFFFFF, 1, 0);
    add(64'hFFF0000000000000, RNE, 1, 0, 0, 64'h8000000000000000, 1, 0);
    add(64'h7FF8000000000000, RNE, 1, 1, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    add(64'h0000000000000001, RUP, 1, 0, 0, 64'd1, 0, 1);
    add(64'h8000000000000001, RDN, 1, 0, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1);

    // Reset state, then release
    #12;
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_output", OUTPUT, 64'd0);
    chk("rst_flags", {62'd0, INVALID, INEXACT}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1 chk("rst_in_ready", 64'(IN_READY), 64'd1);

    foreach (vecs[i]) begin
      send(vecs[i].val, vecs[i].rm, vecs[i].dbl, vecs[i].word, vecs[i].uns);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_output", i), OUTPUT, vecs[i].want);
      chk($sformatf("vec%0d_nv", i), 64'(INVALID), 64'(vecs[i].nv));
      chk($sformatf("vec%0d_nx", i), 64'(INEXACT), 64'(vecs[i].nx));
      consume();
    end

    // Backpressure: result held while OUT_READY is low, new operand refused
    send(64'h4004000000000000, RMM, 1, 0, 0);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd2);
    held = OUTPUT;
    chk("bp_output", held, 64'd3);
    @(negedge CLK);
    INPUT = 64'h3FF0000000000000;
    IN_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("bp_hold%0d", c), {OUTPUT, 3'b000} | 67'd0 >> 0 == {held, 3'b000} ? 64'd1 : 64'd0, 64'd1);
      chk($sformatf("bp_state%0d", c), {62'd0, OUT_VALID, IN_READY}, 64'd2);
      chk($sformatf("bp_flags%0d", c), {62'd0, INVALID, INEXACT}, 64'd1);
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("bp_release", {62'd0, OUT_VALID, IN_READY}, 64'd1);
    OUT_READY = 1'b0;
    IN_VALID = 1'b0;

    // Flush while aligning
    send(64'h4004000000000000, RNE, 1, 0, 0);
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1 FLUSH = 1'b0;
    chk("flush_in_ready", 64'(IN_READY), 64'd1);
    watch_quiet("flush_no_valid", 6);
    send(64'hC004000000000000, RNE, 1, 0, 0);
    wait_valid(lat);
    chk("flush_next_latency", 64'(lat), 64'd2);
    chk("flush_next_output", OUTPUT, 64'hFFFFFFFFFFFFFFFE);
    consume();

    // Reset asserted while rounding
    send(64'h400C000000000000, RNE, 1, 0, 0);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_mid_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_mid_output", OUTPUT, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    watch_quiet("rst_no_valid", 6);
    send(64'h4004000000000000, RUP, 1, 0, 0);
    wait_valid(lat);
    chk("rst_next_latency", 64'(lat), 64'd2);
    chk("rst_next_output", OUTPUT, 64'd3);
    chk("rst_next_nx", 64'(INEXACT), 64'd1);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/falu_cnv_fp2int.md
FALU_CNV_FP2INT -- requirements
Module: falu_cnv_fp2int

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port IN_VALID, input, 1 bit: operand valid.
REQ-004 SHALL have port IN_READY, output, 1 bit: converter can accept an operand.
REQ-005 SHALL have port INPUT, input, 64 bits: FP operand (SP operands NaN-boxed in [63:32]).
REQ-006 SHALL have port Rounding_Mode, input, 3 bits: FCSR_FRM_* encoding.
REQ-007 SHALL have ports IsDouble, IsWord and Is_Unsigned, input, 1 bit each: DP source, 32-bit result, unsigned result.
REQ-008 SHALL have port FLUSH, input, 1 bit: synchronous kill of the in-flight operation.
REQ-009 SHALL have ports OUT_VALID (output, 1 bit) and OUT_READY (input, 1 bit): result handshake.
REQ-010 SHALL have ports OUTPUT, output, 64 bits (integer result), INVALID, output, 1 bit (NV) and INEXACT, output, 1 bit (NX).

Function
REQ-011 SHALL implement FSM IDLE -> ALIGN -> ROUND -> DONE -> IDLE.
REQ-012 SHALL drive IN_READY=1 only in IDLE; IN_VALID&IN_READY at edge N captures all operand and control inputs and enters ALIGN.
REQ-013 SHALL unpack and align in ALIGN: hidden bit 0 for denormals (exponent treated as 1); 64-bit integer magnitude, guard and sticky registered at edge N+1.
REQ-014 SHALL round in ROUND, then range-check and saturate; result, INVALID and INEXACT registered and OUT_VALID=1 from edge N+2.
REQ-015 SHALL apply rounding: RNE = G&(L|S); RTZ = 0; RDN = sign&(G|S); RUP = ~sign&(G|S); RMM = G; any other encoding = RTZ.
REQ-016 SHALL treat an unbiased exponent >= 64 as overflow, and an exponent < -1 as all bits into sticky.
REQ-017 SHALL saturate when the rounded value falls outside the range, with INVALID=1 and INEXACT=0: signed word [-2^31, 2^31-1], unsigned word [0, 2^32-1], signed long [-2^63, 2^63-1], unsigned long [0, 2^64-1].
REQ-018 SHALL give NaN and +inf the maximum value of the range, and -inf the minimum value, with INVALID=1.
REQ-019 SHALL give an unsigned conversion of a negative value that rounds to 0 the result 0, INEXACT=1 and INVALID=0; a negative value that rounds to nonzero saturates to 0 with INVALID=1.
REQ-020 SHALL treat an SP operand with INPUT[63:32] != 32'hFFFFFFFF as canonical NaN.
REQ-021 SHALL sign-extend word results from bit 31 into OUTPUT[63:32], including unsigned word results.
REQ-022 SHALL give ±0 the result 0 with no flags; INEXACT SHALL be (G|S) whenever the result is not saturated.
REQ-023 SHALL hold OUTPUT, INVALID, INEXACT and OUT_VALID stable in DONE until OUT_READY=1, then return to IDLE on that edge with no same-cycle accept.
REQ-024 SHALL make FLUSH=1 force IDLE at the next edge from any state, clearing OUT_VALID; FLUSH SHALL win over simultaneous IN_VALID or OUT_READY.

Reset
REQ-025 SHALL on RST=1 immediately set the state to IDLE, OUT_VALID=0, OUTPUT=0, INVALID=0 and INEXACT=0; IN_READY=1 after release.
REQ-026 SHALL on RST asserted mid-operation discard the operation, with no OUT_VALID pulse after release.

Structure
REQ-027 SHALL take rounding encodings from FCSR_FRM_* in ISA_priv_defines.vh; the saturation constants (word/long min and max) and the SP/DP bias and width constants SHALL be placed in the shared FALU constants header.
REQ-028 SHALL place unpack and classify (sign, exponent, significand, zero/denormal/inf/NaN, boxing check) in sub-module fp2int_unpack; the FSM, aligner and rounder SHALL stay in the top module.

Verification
REQ-029 SHALL cover: DP 2.5 (0x4004000000000000), signed long: RNE -> 2 with NX=1; RMM -> 3 with NX=1; RTZ -> 2.
REQ-030 SHALL cover: SP -1.5 (0xFFFFFFFF_BFC00000), RDN, signed word -> 0xFFFFFFFF_FFFFFFFE, NX=1; same value unboxed (0x00000000_BFC00000) -> 0x00000000_7FFFFFFF, NV=1.
REQ-031 SHALL cover: DP 2^63 (0x43E0000000000000): signed long -> 0x7FFFFFFFFFFFFFFF, NV=1; unsigned long -> 0x8000000000000000 with no flags.
REQ-032 SHALL cover: unsigned long, RTZ: -0.25 (0xBFD0000000000000) -> 0, NX=1, NV=0; -1.0 (0xBFF0000000000000) -> 0, NV=1; unsigned word 4294967295.0 (0x41EFFFFFFFE00000) -> 0xFFFFFFFF_FFFFFFFF with no flags.
REQ-033 SHALL cover: OUT_READY low for 5 cycles -> outputs stable, IN_READY=0; OUT_READY high -> IDLE at the next edge; accept-to-OUT_VALID = 2 cycles.
REQ-034 SHALL cover: FLUSH in ALIGN, and RST asserted in ROUND -> OUT_VALID never asserts; the next operand converts correctly.
